// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: one outstanding imem request, IF/ID register, skid buffer, redirect kill
// Optional FETCH_PERF_EN adds perf_fetched / perf_stall_cycles counters.
module instruction_fetch #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int PC_STEP = 1
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] pc_in,
   output logic [ADDR_W-1:0] next_address,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [DATA_W-1:0] imem_data,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target,
   output logic              ifid_valid,
   output logic [DATA_W-1:0] ifid_instr,
   output logic [ADDR_W-1:0] ifid_pc
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_stall_cycles
`endif
);

   localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

   typedef enum logic [1:0] {
      S_BOOT  = 2'd0,
      S_FETCH = 2'd1,
      S_HOLD  = 2'd2,
      S_KILL  = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [ADDR_W-1:0] kill_addr;
   logic [DATA_W-1:0] skid_instr;
   logic [ADDR_W-1:0] skid_pc;
   logic              fire;

   always_comb begin
      state_next   = state;
      imem_req     = 1'b0;
      imem_addr    = pc_in;
      next_address = pc_in;
      fire         = 1'b0;
      case (state)
         S_BOOT: state_next = S_FETCH;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               fire         = 1'b1;
               next_address = pc_in + STEP;
               if (stall) state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            if (!stall) state_next = S_FETCH;
         end
         S_KILL: begin
            // the abandoned request must still complete at its original address
            imem_req  = 1'b1;
            imem_addr = kill_addr;
            if (imem_ack) state_next = S_FETCH;
         end
         default: state_next = S_BOOT;
      endcase
      if (redirect_valid) begin
         next_address = redirect_target;
         case (state)
            S_FETCH: state_next = imem_ack ? S_FETCH : S_KILL;
            S_KILL:  state_next = S_KILL;
            default: state_next = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= S_BOOT;
         kill_addr  <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else begin
         state <= state_next;
         if (redirect_valid) begin
            ifid_valid <= 1'b0;
            skid_instr <= '0;
            skid_pc    <= '0;
            if (state == S_FETCH && !imem_ack) kill_addr <= pc_in;
         end else if (!stall) begin
            if (fire) begin
               ifid_valid <= 1'b1;
               ifid_instr <= imem_data;
               ifid_pc    <= pc_in;
            end else if (state == S_HOLD) begin
               ifid_valid <= 1'b1;
               ifid_instr <= skid_instr;
               ifid_pc    <= skid_pc;
            end else begin
               ifid_valid <= 1'b0;
            end
         end else if (fire) begin
            skid_instr <= imem_data;
            skid_pc    <= pc_in;
         end
      end
   end

`ifdef FETCH_PERF_EN
   always_ff @(posedge clock) begin
      if (reset) begin
         perf_fetched      <= '0;
         perf_stall_cycles <= '0;
      end else begin
         if (!redirect_valid && !stall && (fire || state == S_HOLD))
            perf_fetched <= perf_fetched + 32'd1;
         if ((imem_req && !imem_ack) || state == S_HOLD)
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
   end
`endif

endmodule
